// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : RISC-V immediate generator with a 2-entry in-order output
//                buffer. Decodes U/J/I/B/S immediates, hart ID and CSR zimm,
//                tags each result with its hart, and supports per-hart flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int          XLEN        = 32,
    parameter int          NUM_HARTS   = 4,
    parameter logic [63:0] HARTID_BASE = 64'd0,
    localparam int         HW          = (NUM_HARTS > 2) ? $clog2(NUM_HARTS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_sel,
    input  logic [24:0]     in_instr,
    input  logic [HW-1:0]   in_hart,
    input  logic            flush,
    input  logic [HW-1:0]   flush_hart,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [HW-1:0]   out_hart,
    output logic            out_err
);

    // Immediate format selectors
    localparam logic [2:0] c_SEL_U    = 3'd0;
    localparam logic [2:0] c_SEL_J    = 3'd1;
    localparam logic [2:0] c_SEL_I    = 3'd2;
    localparam logic [2:0] c_SEL_B    = 3'd3;
    localparam logic [2:0] c_SEL_S    = 3'd4;
    localparam logic [2:0] c_SEL_HART = 3'd5;
    localparam logic [2:0] c_SEL_CSR  = 3'd6;
    localparam logic [2:0] c_SEL_ILL  = 3'd7;

    localparam int c_DEPTH = 2;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [31:0]     w_raw;      // 32-bit result before extension to XLEN
    logic [XLEN-1:0] w_dec_imm;
    logic            w_dec_err;

    // Assemble the 32-bit immediate for the selected format; every format
    // with a sign carries it in bit 31, and the zimm leaves bit 31 clear,
    // so one uniform sign extension to XLEN covers all of them.
    always_comb begin
        w_raw = 32'd0;
        case (in_sel)
            c_SEL_U:   w_raw = {in_instr[24:5], 12'b0};
            c_SEL_J:   w_raw = {{11{in_instr[24]}}, in_instr[24], in_instr[12:5],
                                in_instr[13], in_instr[23:14], 1'b0};
            c_SEL_I:   w_raw = {{20{in_instr[24]}}, in_instr[24:13]};
            c_SEL_B:   w_raw = {{19{in_instr[24]}}, in_instr[24], in_instr[0],
                                in_instr[23:18], in_instr[4:1], 1'b0};
            c_SEL_S:   w_raw = {{20{in_instr[24]}}, in_instr[24:18], in_instr[4:0]};
            c_SEL_CSR: w_raw = {27'd0, in_instr[12:8]};
            default:   w_raw = 32'd0;
        endcase
    end

    // Extend to XLEN, then override for hart ID (modular add) and illegal
    always_comb begin
        w_dec_imm       = {XLEN{w_raw[31]}};
        w_dec_imm[31:0] = w_raw;
        w_dec_err       = 1'b0;
        if (in_sel == c_SEL_HART) begin
            w_dec_imm = HARTID_BASE[XLEN-1:0] + XLEN'(in_hart);
        end
        if (in_sel == c_SEL_ILL) begin
            w_dec_imm = '0;
            w_dec_err = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output buffer: slot 0 is always the head
    // ------------------------------------------------------------------
    logic [1:0]      r_count;
    logic [XLEN-1:0] r_imm  [c_DEPTH];
    logic [HW-1:0]   r_hart [c_DEPTH];
    logic            r_err  [c_DEPTH];

    logic            w_push;
    logic            w_pop;
    logic            w_v    [c_DEPTH];
    logic [XLEN-1:0] w_imm  [c_DEPTH];
    logic [HW-1:0]   w_hart [c_DEPTH];
    logic            w_err  [c_DEPTH];
    logic [1:0]      w_count_nxt;

    // in_ready depends only on stored occupancy (and is held low in reset)
    assign in_ready  = ~reset & (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign out_imm   = r_imm[0];
    assign out_hart  = r_hart[0];
    assign out_err   = r_err[0];

    // A request from the hart being flushed this cycle is dropped on entry
    assign w_push = in_valid & in_ready & ~(flush & (in_hart == flush_hart));
    assign w_pop  = out_valid & out_ready;

    // Next buffer image: retire head on pop, drop flushed entries,
    // close any gap so order is kept, then append the new entry.
    always_comb begin
        w_v[0] = (r_count != 2'd0);
        w_v[1] = (r_count == 2'd2);
        for (int i = 0; i < c_DEPTH; i++) begin
            w_imm[i]  = r_imm[i];
            w_hart[i] = r_hart[i];
            w_err[i]  = r_err[i];
        end

        if (w_pop) begin
            w_v[0]    = w_v[1];
            w_imm[0]  = r_imm[1];
            w_hart[0] = r_hart[1];
            w_err[0]  = r_err[1];
            w_v[1]    = 1'b0;
        end

        if (flush) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                if (w_hart[i] == flush_hart) begin
                    w_v[i] = 1'b0;
                end
            end
        end

        if (!w_v[0] && w_v[1]) begin
            w_v[0]    = 1'b1;
            w_imm[0]  = w_imm[1];
            w_hart[0] = w_hart[1];
            w_err[0]  = w_err[1];
            w_v[1]    = 1'b0;
        end

        // in_ready guarantees at most one survivor when pushing
        if (w_push) begin
            if (w_v[0]) begin
                w_v[1]    = 1'b1;
                w_imm[1]  = w_dec_imm;
                w_hart[1] = in_hart;
                w_err[1]  = w_dec_err;
            end else begin
                w_v[0]    = 1'b1;
                w_imm[0]  = w_dec_imm;
                w_hart[0] = in_hart;
                w_err[0]  = w_dec_err;
            end
        end

        w_count_nxt = {1'b0, w_v[0]} + {1'b0, w_v[1]};
    end

    // Buffer state register; reset empties the buffer immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 2'd0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_imm[i]  <= '0;
                r_hart[i] <= '0;
                r_err[i]  <= 1'b0;
            end
        end else begin
            r_count <= w_count_nxt;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_imm[i]  <= w_imm[i];
                r_hart[i] <= w_hart[i];
                r_err[i]  <= w_err[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_gen_pipe
//  Description : Self-checking bench for imm_gen_pipe. Drives a 32-bit and a
//                64-bit instance with identical stimulus and compares both to
//                a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    localparam logic [63:0] c_BASE32 = 64'd16;
    localparam logic [63:0] c_BASE64 = 64'hFFFF_FFFF_FFFF_FFFE;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [2:0]  in_sel;
    logic [24:0] in_instr;
    logic [1:0]  in_hart;
    logic        flush;
    logic [1:0]  flush_hart;
    logic        out_ready;

    logic        rdy32, vld32, err32;
    logic [31:0] imm32;
    logic [1:0]  hart32;
    logic        rdy64, vld64, err64;
    logic [63:0] imm64;
    logic [1:0]  hart64;

    imm_gen_pipe #(.XLEN(32), .NUM_HARTS(4), .HARTID_BASE(c_BASE32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
        .in_sel(in_sel), .in_instr(in_instr), .in_hart(in_hart),
        .flush(flush), .flush_hart(flush_hart), .out_valid(vld32),
        .out_ready(out_ready), .out_imm(imm32), .out_hart(hart32), .out_err(err32)
    );

    imm_gen_pipe #(.XLEN(64), .NUM_HARTS(4), .HARTID_BASE(c_BASE64)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
        .in_sel(in_sel), .in_instr(in_instr), .in_hart(in_hart),
        .flush(flush), .flush_hart(flush_hart), .out_valid(vld64),
        .out_ready(out_ready), .out_imm(imm64), .out_hart(hart64), .out_err(err64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] i32;
        logic [63:0] i64;
        logic [1:0]  hart;
        logic        err;
    } ent_t;

    ent_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Sign-interpret the low n bits of v
    function automatic logic [63:0] sext(input logic [63:0] v, input int n);
        return v[n-1] ? v - (64'd1 << n) : v;
    endfunction

    // Reference decode from the architectural instruction word
    function automatic logic [63:0] ref_imm(input int xlen, input logic [63:0] base,
                                            input logic [2:0] sel, input logic [24:0] instr,
                                            input logic [1:0] hart);
        logic [31:0] ins;
        logic [63:0] r;
        ins = {instr, 7'b0};
        case (sel)
            3'd0: r = sext(64'(ins[31:12]) << 12, 32);
            3'd1: r = sext((64'(ins[31]) << 20) | (64'(ins[19:12]) << 12) |
                           (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1), 21);
            3'd2: r = sext(64'(ins[31:20]), 12);
            3'd3: r = sext((64'(ins[31]) << 12) | (64'(ins[7]) << 11) |
                           (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1), 13);
            3'd4: r = sext((64'(ins[31:25]) << 5) | 64'(ins[11:7]), 12);
            3'd5: r = base + 64'(hart);
            3'd6: r = 64'(ins[19:15]);
            default: r = 64'd0;
        endcase
        if (xlen == 32) r = r & 64'hFFFF_FFFF;
        return r;
    endfunction

    task automatic check_outputs();
        logic exp_v;
        logic exp_r;
        exp_v = (q.size() != 0);
        exp_r = (q.size() < 2);
        check("in_ready32", 64'(rdy32), 64'(exp_r));
        check("in_ready64", 64'(rdy64), 64'(exp_r));
        check("out_valid32", 64'(vld32), 64'(exp_v));
        check("out_valid64", 64'(vld64), 64'(exp_v));
        if (exp_v) begin
            check("imm32", 64'(imm32), q[0].i32);
            check("imm64", imm64, q[0].i64);
            check("hart32", 64'(hart32), 64'(q[0].hart));
            check("hart64", 64'(hart64), 64'(q[0].hart));
            check("err32", 64'(err32), 64'(q[0].err));
            check("err64", 64'(err64), 64'(q[0].err));
        end
    endtask

    // One cycle: check state at negedge, drive inputs, advance the model
    task automatic step(input logic v, input logic [2:0] s, input logic [24:0] ins,
                        input logic [1:0] h, input logic f, input logic [1:0] fh,
                        input logic ordy);
        logic rdy;
        ent_t nq[$];
        @(negedge clk);
        check_outputs();
        in_valid   = v;
        in_sel     = s;
        in_instr   = ins;
        in_hart    = h;
        flush      = f;
        flush_hart = fh;
        out_ready  = ordy;
        rdy = (q.size() < 2);
        if (q.size() != 0 && ordy) void'(q.pop_front());
        if (f) begin
            foreach (q[i]) if (q[i].hart != fh) nq.push_back(q[i]);
            q = nq;
        end
        if (v && rdy && !(f && h == fh))
            q.push_back('{ref_imm(32, c_BASE32, s, ins, h), ref_imm(64, c_BASE64, s, ins, h),
                          h, (s == 3'd7)});
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 3'd0, 25'd0, 2'd0, 1'b0, 2'd0, ordy);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_sel = 3'd0; in_instr = 25'd0;
        in_hart = 2'd0; flush = 1'b0; flush_hart = 2'd0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid32", 64'(vld32), 64'd0);
        check("rst_ready32", 64'(rdy32), 64'd0);
        check("rst_ready64", 64'(rdy64), 64'd0);
        check("rst_imm64", imm64, 64'd0);
        check("rst_hart32", 64'(hart32), 64'd0);
        check("rst_err32", 64'(err32), 64'd0);
        reset = 1'b0;

        // I-type -1
        step(1'b1, 3'd2, 25'h1FFE000, 2'd0, 1'b0, 2'd0, 1'b0);
        idle(1'b1);
        check("i_neg1_valid", 64'(vld32), 64'd1);
        check("i_neg1_imm32", 64'(imm32), 64'hFFFF_FFFF);
        check("i_neg1_err", 64'(err32), 64'd0);

        // U-type with sign bit set on 64-bit instance
        step(1'b1, 3'd0, 25'h1000000, 2'd0, 1'b0, 2'd0, 1'b0);
        idle(1'b1);
        check("u_imm64", imm64, 64'hFFFF_FFFF_8000_0000);

        // Hart ID and illegal selector
        step(1'b1, 3'd5, 25'd0, 2'd3, 1'b0, 2'd0, 1'b0);
        idle(1'b1);
        check("hartid_imm32", 64'(imm32), 64'd19);
        check("hartid_hart", 64'(hart32), 64'd3);
        check("hartid_wrap64", imm64, 64'd1);
        step(1'b1, 3'd7, 25'h1ABCDEF, 2'd1, 1'b0, 2'd0, 1'b0);
        idle(1'b1);
        check("ill_imm32", 64'(imm32), 64'd0);
        check("ill_err32", 64'(err32), 64'd1);

        // Back-to-back pushes with consumer stalled
        step(1'b1, 3'd5, 25'd0, 2'd0, 1'b0, 2'd0, 1'b0);
        step(1'b1, 3'd5, 25'd0, 2'd1, 1'b0, 2'd0, 1'b0);
        step(1'b1, 3'd5, 25'd0, 2'd2, 1'b0, 2'd0, 1'b0);
        check("full_ready", 64'(rdy32), 64'd0);
        idle(1'b1);
        check("drain_first", 64'(hart32), 64'd0);
        idle(1'b1);
        check("drain_second", 64'(hart32), 64'd1);
        idle(1'b1);
        check("drain_empty", 64'(vld32), 64'd0);

        // Flush of the head hart promotes the tail
        step(1'b1, 3'd5, 25'd0, 2'd0, 1'b0, 2'd0, 1'b0);
        step(1'b1, 3'd5, 25'd0, 2'd1, 1'b0, 2'd0, 1'b0);
        step(1'b0, 3'd0, 25'd0, 2'd0, 1'b1, 2'd0, 1'b0);
        idle(1'b0);
        check("flush_head", 64'(hart32), 64'd1);
        check("flush_count1", 64'(rdy32), 64'd1);

        // Asynchronous reset with a full buffer
        step(1'b1, 3'd5, 25'd0, 2'd2, 1'b0, 2'd0, 1'b0);
        idle(1'b0);
        #2 reset = 1'b1;
        #1;
        check("arst_valid32", 64'(vld32), 64'd0);
        check("arst_valid64", 64'(vld64), 64'd0);
        check("arst_ready", 64'(rdy32), 64'd0);
        check("arst_imm32", 64'(imm32), 64'd0);
        q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(1'b1);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            logic [24:0] ins;
            ins = 25'($urandom);
            if (k % 10 == 0) ins = 25'h1FFFFFF;
            if (k % 10 == 5) ins = 25'd0;
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), ins,
                 2'($urandom_range(0, 3)), $urandom_range(0, 6) == 0,
                 2'($urandom_range(0, 3)), $urandom_range(0, 4) < 3);
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
